// File: rtl/io_burst_master_if.sv
// io_burst_master_if
//   Bundles every signal of the burst master except clock and reset:
//   - the client command channel (cmd_*)
//   - the write-data stream (wr_*)
//   - the read-data stream (rd_*)
//   - status (busy, done)
//   - the SRAM controller IO request port (io_*)
//   Modports:
//   - master: the view of io_burst_master itself.
//   - slave:  the combined view of the client and the controller.
interface io_burst_master_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [18:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic        wr_valid;
   logic [7:0]  wr_data;
   logic        wr_ready;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic        rd_ready;
   logic        busy;
   logic        done;
   logic        io_req;
   logic        io_we;
   logic [18:0] io_addr;
   logic [7:0]  io_write_data;
   logic [7:0]  io_data;
   logic        io_ready;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_len,
      input  wr_valid, wr_data,
      input  rd_ready,
      input  io_data, io_ready,
      output cmd_ready, wr_ready, rd_valid, rd_data,
      output busy, done,
      output io_req, io_we, io_addr, io_write_data
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_len,
      output wr_valid, wr_data,
      output rd_ready,
      output io_data, io_ready,
      input  cmd_ready, wr_ready, rd_valid, rd_data,
      input  busy, done,
      input  io_req, io_we, io_addr, io_write_data
   );
endinterface

// File: rtl/io_burst_master.sv
// io_burst_master
//   Burst initiator for the SRAM controller IO port. It accepts one burst
//   command (start address, beat count, direction) and then issues one byte
//   access per beat, incrementing the address modulo 2^19 after each beat.
//   Write bytes are pulled from a valid/ready stream. Read bytes are pushed
//   into a single-entry output register with a valid/ready handshake.
// Ports:
//   clk  - clock
//   clr  - asynchronous active-low reset
//   bus  - io_burst_master_if.master (command, wr/rd streams, status, IO port)
module io_burst_master (
   input  logic                   clk,
   input  logic                   clr,
   io_burst_master_if.master      bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WDATA,
      S_REQ,
      S_ACK,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [18:0] addr_q, addr_d;
   logic [7:0]  remaining_q, remaining_d;
   logic        write_q, write_d;
   logic        io_req_q, io_req_d;
   logic        io_we_q, io_we_d;
   logic [18:0] io_addr_q, io_addr_d;
   logic [7:0]  io_wdata_q, io_wdata_d;
   logic        rd_valid_q, rd_valid_d;
   logic [7:0]  rd_data_q, rd_data_d;

   logic        done_w;
   logic [18:0] addr_inc;

   assign addr_inc = addr_q + 19'd1;

   // Completion also fires when the last read byte is being consumed at this
   // very edge, so the pulse does not wait an extra cycle for rd_valid to drop.
   assign done_w = (state_q == S_DONE) && (!rd_valid_q || bus.rd_ready);

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      write_d     = write_q;
      io_req_d    = io_req_q;
      io_we_d     = io_we_q;
      io_addr_d   = io_addr_q;
      io_wdata_d  = io_wdata_q;
      rd_valid_d  = rd_valid_q;
      rd_data_d   = rd_data_q;

      // Consumption first; a capture below in the same cycle overrides it.
      if (rd_valid_q && bus.rd_ready) begin
         rd_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               addr_d      = bus.cmd_addr;
               remaining_d = bus.cmd_len;
               write_d     = bus.cmd_write;
               if (bus.cmd_len == 8'd0) begin
                  state_d = S_DONE;
               end else if (bus.cmd_write) begin
                  state_d = S_WDATA;
               end else begin
                  state_d   = S_REQ;
                  io_req_d  = 1'b1;
                  io_we_d   = 1'b0;
                  io_addr_d = bus.cmd_addr;
               end
            end
         end

         S_WDATA: begin
            if (bus.wr_valid) begin
               io_wdata_d = bus.wr_data;
               io_req_d   = 1'b1;
               io_we_d    = 1'b1;
               io_addr_d  = addr_q;
               state_d    = S_REQ;
            end
         end

         S_REQ: begin
            // io_ready is ignored here: it may still reflect the previous beat.
            // A read holds in REQ while the output register is full and not
            // being drained; the repeated controller read is harmless.
            if (write_q || !rd_valid_q || bus.rd_ready) begin
               state_d = S_ACK;
            end
         end

         S_ACK: begin
            if (bus.io_ready) begin
               remaining_d = remaining_q - 8'd1;
               addr_d      = addr_inc;
               if (!write_q) begin
                  rd_data_d  = bus.io_data;
                  rd_valid_d = 1'b1;
               end
               if (remaining_q == 8'd1) begin
                  state_d  = S_DONE;
                  io_req_d = 1'b0;
               end else if (!write_q) begin
                  state_d   = S_REQ;
                  io_addr_d = addr_inc;
               end else begin
                  state_d  = S_WDATA;
                  io_req_d = 1'b0;
               end
            end
         end

         S_DONE: begin
            if (done_w) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         write_q     <= 1'b0;
         io_req_q    <= 1'b0;
         io_we_q     <= 1'b0;
         io_addr_q   <= '0;
         io_wdata_q  <= '0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         write_q     <= write_d;
         io_req_q    <= io_req_d;
         io_we_q     <= io_we_d;
         io_addr_q   <= io_addr_d;
         io_wdata_q  <= io_wdata_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
      end
   end

   assign bus.cmd_ready     = (state_q == S_IDLE);
   assign bus.wr_ready      = (state_q == S_WDATA);
   assign bus.busy          = (state_q != S_IDLE);
   assign bus.done          = done_w;
   assign bus.rd_valid      = rd_valid_q;
   assign bus.rd_data       = rd_data_q;
   assign bus.io_req        = io_req_q;
   assign bus.io_we         = io_we_q;
   assign bus.io_addr       = io_addr_q;
   assign bus.io_write_data = io_wdata_q;

endmodule

// File: tb/tb_io_burst_master.sv
// tb_io_burst_master
//   Directed bench for io_burst_master. A small SRAM controller model samples
//   io_req each cycle and returns io_ready one cycle later (optionally stalled);
//   memory is preloaded with mem[a] = a[7:0] ^ 0x5A, except mem[0x10] = 0xA5.
module tb_io_burst_master;

   logic clk;
   logic clr;
   logic stall;
   logic io_ready_r;
   logic [7:0] io_data_r;
   logic [7:0] mem [0:524287];

   int unsigned n_assert;
   int unsigned n_fail;

   io_burst_master_if bus ();

   io_burst_master dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Controller model: one-cycle registered response to whatever request is up.
   always @(posedge clk) begin
      if (bus.io_req) begin
         if (bus.io_we) mem[bus.io_addr] = bus.io_write_data;
         io_data_r <= mem[bus.io_addr];
      end
      io_ready_r <= bus.io_req && !stall;
   end

   assign bus.io_ready = io_ready_r;
   assign bus.io_data  = io_data_r;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic wr, input logic [18:0] a, input logic [7:0] len);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = a;
      bus.cmd_len   = len;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      stall    = 1'b0;
      io_ready_r = 1'b0;
      io_data_r  = '0;
      for (int i = 0; i < 524288; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[19'h10] = 8'hA5;

      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_len   = '0;
      bus.wr_valid  = 1'b0;
      bus.wr_data   = '0;
      bus.rd_ready  = 1'b1;

      // ---------------- reset state
      clr = 1'b0;
      tick();
      tick();
      check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check("rst_busy",      32'(bus.busy),      32'd0);
      check("rst_io_req",    32'(bus.io_req),    32'd0);
      check("rst_io_addr",   32'(bus.io_addr),   32'd0);
      check("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
      check("rst_done",      32'(bus.done),      32'd0);
      check("rst_wr_ready",  32'(bus.wr_ready),  32'd0);
      clr = 1'b1;
      tick();

      // ---------------- read, len 1 at 0x10
      send_cmd(1'b0, 19'h00010, 8'd1);
      tick();
      bus.cmd_valid = 1'b0;
      check("r1_c1_io_req",  32'(bus.io_req),  32'd1);
      check("r1_c1_io_we",   32'(bus.io_we),   32'd0);
      check("r1_c1_io_addr", 32'(bus.io_addr), 32'h10);
      check("r1_c1_busy",    32'(bus.busy),    32'd1);
      check("r1_c1_cmd_rdy", 32'(bus.cmd_ready), 32'd0);
      tick();
      check("r1_c2_io_req",  32'(bus.io_req),  32'd1);
      check("r1_c2_rd_valid", 32'(bus.rd_valid), 32'd0);
      tick();
      check("r1_c3_rd_valid", 32'(bus.rd_valid), 32'd1);
      check("r1_c3_rd_data", 32'(bus.rd_data), 32'hA5);
      check("r1_c3_io_req",  32'(bus.io_req),  32'd0);
      check("r1_c3_done",    32'(bus.done),    32'd1);
      tick();
      check("r1_c4_done",    32'(bus.done),    32'd0);
      check("r1_c4_rd_valid", 32'(bus.rd_valid), 32'd0);
      check("r1_c4_cmd_rdy", 32'(bus.cmd_ready), 32'd1);

      // ---------------- write, len 4 at 0x7FFFE with wrap
      send_cmd(1'b1, 19'h7FFFE, 8'd4);
      bus.wr_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         logic [7:0]  wd;
         logic [18:0] wa;
         wd = 8'h11 * 8'(b + 1);
         wa = 19'h7FFFE + 19'(b);
         bus.wr_data = wd;
         check("w4_wr_ready", 32'(bus.wr_ready), 32'd1);
         check("w4_wdata_io_req", 32'(bus.io_req), 32'd0);
         tick();
         check("w4_req_io_req",  32'(bus.io_req), 32'd1);
         check("w4_req_io_we",   32'(bus.io_we),  32'd1);
         check("w4_req_io_addr", 32'(bus.io_addr), 32'(wa));
         check("w4_req_io_wdata", 32'(bus.io_write_data), 32'(wd));
         check("w4_req_done",    32'(bus.done), 32'd0);
         tick();
         check("w4_ack_io_req",  32'(bus.io_req), 32'd1);
         tick();
      end
      bus.wr_valid = 1'b0;
      check("w4_done",        32'(bus.done),   32'd1);
      check("w4_done_io_req", 32'(bus.io_req), 32'd0);
      tick();
      check("w4_done_gone",   32'(bus.done),   32'd0);
      check("w4_idle",        32'(bus.cmd_ready), 32'd1);
      check("w4_mem_7fffe",   32'(mem[19'h7FFFE]), 32'h11);
      check("w4_mem_7ffff",   32'(mem[19'h7FFFF]), 32'h22);
      check("w4_mem_00000",   32'(mem[19'h00000]), 32'h33);
      check("w4_mem_00001",   32'(mem[19'h00001]), 32'h44);

      // ---------------- read, len 3 at 0x100 with rd_ready backpressure
      bus.rd_ready = 1'b0;
      send_cmd(1'b0, 19'h00100, 8'd3);
      tick();
      bus.cmd_valid = 1'b0;
      check("bp_c1_io_addr", 32'(bus.io_addr), 32'h100);
      tick();
      tick();
      check("bp_b0_rd_valid", 32'(bus.rd_valid), 32'd1);
      check("bp_b0_rd_data", 32'(bus.rd_data), 32'h5A);
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_io_req",  32'(bus.io_req),  32'd1);
         check("bp_hold_io_addr", 32'(bus.io_addr), 32'h101);
         check("bp_hold_rd_data", 32'(bus.rd_data), 32'h5A);
         check("bp_hold_rd_valid", 32'(bus.rd_valid), 32'd1);
         tick();
      end
      check("bp_still_addr", 32'(bus.io_addr), 32'h101);
      check("bp_still_data", 32'(bus.rd_data), 32'h5A);
      bus.rd_ready = 1'b1;
      tick();
      check("bp_ack1_rd_valid", 32'(bus.rd_valid), 32'd0);
      tick();
      check("bp_b1_rd_valid", 32'(bus.rd_valid), 32'd1);
      check("bp_b1_rd_data", 32'(bus.rd_data), 32'h5B);
      check("bp_b1_io_addr", 32'(bus.io_addr), 32'h102);
      tick();
      tick();
      check("bp_b2_rd_data", 32'(bus.rd_data), 32'h58);
      check("bp_b2_done",    32'(bus.done),    32'd1);
      tick();
      check("bp_idle",       32'(bus.cmd_ready), 32'd1);

      // ---------------- read with controller stall in ACK
      stall = 1'b1;
      send_cmd(1'b0, 19'h00010, 8'd1);
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("st_ack_io_req",  32'(bus.io_req),  32'd1);
         check("st_ack_io_addr", 32'(bus.io_addr), 32'h10);
         check("st_ack_rd_valid", 32'(bus.rd_valid), 32'd0);
         if (i < 2) tick();
      end
      stall = 1'b0;
      tick();
      check("st_ack_wait_rd_valid", 32'(bus.rd_valid), 32'd0);
      tick();
      check("st_rd_valid", 32'(bus.rd_valid), 32'd1);
      check("st_rd_data",  32'(bus.rd_data),  32'hA5);
      check("st_done",     32'(bus.done),     32'd1);
      tick();

      // ---------------- zero-length command
      send_cmd(1'b0, 19'h00055, 8'd0);
      tick();
      bus.cmd_valid = 1'b0;
      check("z_done",      32'(bus.done),      32'd1);
      check("z_io_req",    32'(bus.io_req),    32'd0);
      check("z_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      tick();
      check("z_done_gone", 32'(bus.done),      32'd0);
      check("z_cmd_ready2", 32'(bus.cmd_ready), 32'd1);
      check("z_io_req2",   32'(bus.io_req),    32'd0);

      // ---------------- reset during beat 2 of a 4-beat write
      send_cmd(1'b1, 19'h00200, 8'd4);
      bus.wr_valid = 1'b1;
      bus.wr_data  = 8'hC3;
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      tick();
      tick();
      tick();
      check("cr_pre_io_req",  32'(bus.io_req),  32'd1);
      check("cr_pre_io_addr", 32'(bus.io_addr), 32'h201);
      clr = 1'b0;
      #1;
      check("cr_io_req",    32'(bus.io_req),        32'd0);
      check("cr_io_we",     32'(bus.io_we),         32'd0);
      check("cr_io_addr",   32'(bus.io_addr),       32'd0);
      check("cr_io_wdata",  32'(bus.io_write_data), 32'd0);
      check("cr_busy",      32'(bus.busy),          32'd0);
      check("cr_cmd_ready", 32'(bus.cmd_ready),     32'd1);
      check("cr_wr_ready",  32'(bus.wr_ready),      32'd0);
      bus.wr_valid = 1'b0;
      #2;
      clr = 1'b1;
      tick();
      send_cmd(1'b0, 19'h00010, 8'd1);
      tick();
      bus.cmd_valid = 1'b0;
      check("cr_new_busy",    32'(bus.busy),    32'd1);
      check("cr_new_io_addr", 32'(bus.io_addr), 32'h10);
      tick();
      tick();
      check("cr_new_rd_data", 32'(bus.rd_data), 32'hA5);
      check("cr_new_done",    32'(bus.done),    32'd1);
      tick();

      // ---------------- command held during an active burst
      send_cmd(1'b0, 19'h00100, 8'd2);
      tick();
      bus.cmd_addr = 19'h00010;
      bus.cmd_len  = 8'd1;
      for (int c = 1; c <= 5; c++) begin
         check("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         check("hold_busy",      32'(bus.busy),      32'd1);
         if (c == 3) check("hold_b0_data", 32'(bus.rd_data), 32'h5A);
         if (c == 5) begin
            check("hold_b1_data", 32'(bus.rd_data), 32'h5B);
            check("hold_done",    32'(bus.done),    32'd1);
         end
         tick();
      end
      check("hold_idle_ready", 32'(bus.cmd_ready), 32'd1);
      check("hold_idle_done",  32'(bus.done),      32'd0);
      tick();
      bus.cmd_valid = 1'b0;
      check("hold_2nd_io_req",  32'(bus.io_req),  32'd1);
      check("hold_2nd_io_addr", 32'(bus.io_addr), 32'h10);
      tick();
      tick();
      check("hold_2nd_data", 32'(bus.rd_data), 32'hA5);
      check("hold_2nd_done", 32'(bus.done),    32'd1);
      tick();
      check("hold_end_idle", 32'(bus.cmd_ready), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Absolute time limit so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: observed no end of test, expected completion");
      $fatal(1, "timeout");
   end

endmodule
